// File: rtl/top.sv
// Registered Q8.8 -> signed 8-bit converter: round to nearest, saturate high, sticky overflow.
// Define ROUND_HALF_EVEN_EN to resolve exact .5 ties to the even integer instead of rounding up.
module top (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] fixed_point_in,
  input  logic        ovf_clr,
  output logic        out_valid,
  output logic [7:0]  rounded_integer_out,
  output logic        overflow,
  output logic        ovf_sticky
);

  localparam int unsigned IN_W   = 16;
  localparam int unsigned FRAC_W = 8;
  localparam int unsigned OUT_W  = 8;
  localparam int unsigned TMP_W  = OUT_W + 1;

  localparam logic signed [TMP_W-1:0] SAT_MAX   = 9'sd127;
  localparam logic        [OUT_W-1:0] OUT_MAX   = 8'h7F;
  localparam logic        [FRAC_W-1:0] FRAC_HALF = 8'h80;

`ifdef ROUND_HALF_EVEN_EN
  localparam logic HALF_EVEN = 1'b1;
`else
  localparam logic HALF_EVEN = 1'b0;
`endif

  logic signed [TMP_W-1:0] half_up_c;
  logic signed [TMP_W-1:0] temp_res_c;
  logic                    tie_c;
  logic                    floor_even_c;
  logic                    sat_c;
  logic [OUT_W-1:0]        sat_out_c;

  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] result_q, result_d;
  logic             overflow_q, overflow_d;
  logic             sticky_q, sticky_d;

  // (x + 0.5) >>> 8 equals floor(x) plus the fraction MSB, so no wide adder is needed
  always_comb begin
    half_up_c    = {fixed_point_in[IN_W-1], fixed_point_in[IN_W-1:FRAC_W]}
                 + TMP_W'(fixed_point_in[FRAC_W-1]);
    tie_c        = (fixed_point_in[FRAC_W-1:0] == FRAC_HALF);
    floor_even_c = ~fixed_point_in[FRAC_W];
    temp_res_c   = half_up_c - TMP_W'(HALF_EVEN & tie_c & floor_even_c);
    sat_c        = (temp_res_c > SAT_MAX);
    sat_out_c    = sat_c ? OUT_MAX : temp_res_c[OUT_W-1:0];
  end

  // Data and flag hold between valid samples; set beats clear on the sticky bit
  always_comb begin
    out_valid_d = in_valid;
    result_d    = result_q;
    overflow_d  = overflow_q;
    sticky_d    = sticky_q;
    if (in_valid) begin
      result_d   = sat_out_c;
      overflow_d = sat_c;
    end
    if (ovf_clr) begin
      sticky_d = 1'b0;
    end
    if (in_valid && sat_c) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      sticky_q    <= sticky_d;
    end
  end

  assign out_valid           = out_valid_q;
  assign rounded_integer_out = result_q;
  assign overflow            = overflow_q;
  assign ovf_sticky          = sticky_q;

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: spec vector table, saturation/wrap sweep and
// hand-written sequences for sticky clear, gaps and asynchronous reset.
module tb_top;

  typedef struct packed {
    logic [7:0] data;
    logic       ovf;
  } exp_t;

  typedef struct {
    logic [15:0] din;
    logic [7:0]  eout;
    logic        eovf;
    string       name;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] fixed_point_in;
  logic        ovf_clr;
  logic        out_valid;
  logic [7:0]  rounded_integer_out;
  logic        overflow;
  logic        ovf_sticky;

  int   tests;
  int   failed;
  exp_t sb_q[$];
  exp_t m_last;
  logic m_sticky;

  top dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .in_valid            (in_valid),
    .fixed_point_in      (fixed_point_in),
    .ovf_clr             (ovf_clr),
    .out_valid           (out_valid),
    .rounded_integer_out (rounded_integer_out),
    .overflow            (overflow),
    .ovf_sticky          (ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference conversion written as integer floor/fraction arithmetic
  function automatic void ref_conv(input logic [15:0] d, output logic [7:0] o, output logic ovf);
    int v, fl, fr, r;
    v  = int'($signed(d));
    fl = v >>> 8;
    fr = v & 255;
`ifdef ROUND_HALF_EVEN_EN
    if (fr > 128)       r = fl + 1;
    else if (fr == 128) r = fl + (fl & 1);
    else                r = fl;
`else
    r = fl + ((fr >= 128) ? 1 : 0);
`endif
    if (r > 127) begin
      o   = 8'h7F;
      ovf = 1'b1;
    end else begin
      o   = 8'(r);
      ovf = 1'b0;
    end
  endfunction

  task automatic step(input logic v, input logic [15:0] d, input logic clr,
                      input logic [7:0] eo, input logic eovf, input string nm);
    exp_t e;
    @(negedge clk);
    in_valid       = v;
    fixed_point_in = d;
    ovf_clr        = clr;
    if (v) begin
      e.data = eo;
      e.ovf  = eovf;
      sb_q.push_back(e);
    end
    if (v && eovf) m_sticky = 1'b1;
    else if (clr)  m_sticky = 1'b0;
    @(posedge clk);
    #1;
    chk({nm, " out_valid"}, 32'(out_valid), 32'(v));
    if (out_valid) begin
      if (sb_q.size() == 0) chk({nm, " scoreboard_empty"}, 32'd0, 32'd1);
      else m_last = sb_q.pop_front();
    end
    chk({nm, " data"}, 32'(rounded_integer_out), 32'(m_last.data));
    chk({nm, " overflow"}, 32'(overflow), 32'(m_last.ovf));
    chk({nm, " sticky"}, 32'(ovf_sticky), 32'(m_sticky));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " out_valid"}, 32'(out_valid), 32'd0);
    chk({nm, " data"}, 32'(rounded_integer_out), 32'd0);
    chk({nm, " overflow"}, 32'(overflow), 32'd0);
    chk({nm, " sticky"}, 32'(ovf_sticky), 32'd0);
  endtask

  initial begin
    vec_t        vecs[13];
    logic [7:0]  eo;
    logic        eovf;
    logic [15:0] d;

    vecs[0]  = '{16'h7F7F, 8'h7F, 1'b0, "v_127p496"};
    vecs[1]  = '{16'h8000, 8'h80, 1'b0, "v_min"};
    vecs[2]  = '{16'h807F, 8'h80, 1'b0, "v_807f"};
`ifdef ROUND_HALF_EVEN_EN
    vecs[3]  = '{16'h8080, 8'h80, 1'b0, "v_8080"};
    vecs[4]  = '{16'h0280, 8'h02, 1'b0, "v_2p5"};
    vecs[6]  = '{16'hFE80, 8'hFE, 1'b0, "v_m1p5"};
`else
    vecs[3]  = '{16'h8080, 8'h81, 1'b0, "v_8080"};
    vecs[4]  = '{16'h0280, 8'h03, 1'b0, "v_2p5"};
    vecs[6]  = '{16'hFE80, 8'hFF, 1'b0, "v_m1p5"};
`endif
    vecs[5]  = '{16'h0380, 8'h04, 1'b0, "v_3p5"};
    vecs[7]  = '{16'h0000, 8'h00, 1'b0, "v_zero"};
    vecs[8]  = '{16'hFF80, 8'h00, 1'b0, "v_m0p5"};
    vecs[9]  = '{16'h0040, 8'h00, 1'b0, "v_0p25"};
    vecs[10] = '{16'hFFC0, 8'h00, 1'b0, "v_m0p25"};
    vecs[11] = '{16'h1234, 8'h12, 1'b0, "v_18p2"};
    vecs[12] = '{16'h7F80, 8'h7F, 1'b1, "v_127p5"};

    tests = 0;
    failed = 0;
    m_last = '0;
    m_sticky = 1'b0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    fixed_point_in = '0;
    ovf_clr = 1'b0;

    // Reset held while inputs toggle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = i[0];
      fixed_point_in = 16'h7FFF;
      @(posedge clk);
      #1;
      chk_zero("in_reset");
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;

    step(1'b1, 16'h0100, 1'b0, 8'h01, 1'b0, "first_after_rst");

    foreach (vecs[i]) step(1'b1, vecs[i].din, 1'b0, vecs[i].eout, vecs[i].eovf, vecs[i].name);

    // Clear alone, then back-to-back saturation sweep wrapping into negatives
    step(1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, "clr_alone");
    for (int i = 0; i < 149; i++) begin
      d = 16'h7FFA + 16'(i);
      ref_conv(d, eo, eovf);
      step(1'b1, d, 1'b0, eo, eovf, "sweep");
    end

    step(1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, "clr_alone2");
    step(1'b1, 16'h7FFF, 1'b1, 8'h7F, 1'b1, "clr_vs_set");

    for (int i = 0; i < 3; i++) step(1'b0, 16'h1234, 1'b0, 8'h00, 1'b0, "gap");
    step(1'b1, 16'h00C0, 1'b0, 8'h01, 1'b0, "resume_0p75");

    // Asynchronous reset mid-cycle with saturated data and sticky set
    step(1'b1, 16'h7FFF, 1'b0, 8'h7F, 1'b1, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    sb_q.delete();
    m_last = '0;
    m_sticky = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step(1'b1, 16'hFF00, 1'b0, 8'hFF, 1'b0, "post_rst");

    for (int i = 0; i < 40; i++) begin
      d = 16'($urandom);
      ref_conv(d, eo, eovf);
      step(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)), eo, eovf, "random");
    end

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
